axi_lite_master_cmd: RTL
========================

Name: axi_lite_master_cmd

Overview:
Parametrised AXI4-Lite master driven by a simple command/response interface. It turns one user command (read or write) into a full AXI-Lite transaction and returns the data and response on a handshaked response port. Compared with the earlier fixed 32-bit master, it adds configurable address/data widths, write strobes, a PROT field and a response-watchdog. It sits between control logic (register sequencers, CPU bridges) and an AXI-Lite interconnect.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr/cmd_addr
DATA_WIDTH, 32, data width; legal values are 32 and 64; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, watchdog limit in cycles per bus phase; 0 disables the watchdog

Ports:
axi_lite_aclk  in  1  clock
axi_lite_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  AxPROT value
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP
timeout_err  out  1  sticky watchdog flag
axi_lite_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master-side directions and widths (ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 3, 2).

Behaviour:
- Reset (async assert, sync deassert at module boundary is the system's job): state=IDLE; all *valid, *ready, rsp_* and timeout_err outputs 0; address/data/strobe/prot outputs 0.
- One transaction outstanding at a time. cmd_ready=1 only in IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: on cmd_valid, register all cmd fields, clear timeout_err, go to WR_REQ (write) or RD_REQ (read). Next cycle awvalid/wvalid (or arvalid) = 1.
- WR_REQ: awvalid and wvalid asserted together; each dropped independently on the cycle after its own handshake. Both handshakes may occur in the same cycle or in either order. Once both are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, capture bresp, drop bready, go to RSP.
- RD_REQ: arvalid held until arready; then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&rready, capture rdata/rresp, drop rready, go to RSP.
- RSP: rsp_valid=1 with stable fields until rsp_ready; then go to IDLE. Minimum command-to-rsp_valid latency is 3 cycles for a read and 3 cycles for a write, with zero-wait slaves.
- Valids are never withdrawn before the handshake; address/data/strobe are stable while valid is high (AXI rule).
- bready/rready are asserted only in their wait states; never pre-asserted.
- Watchdog: a counter is cleared on every state change and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA. When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky) and the counter saturates. The transaction continues; the protocol is not violated. timeout_err clears only on the next command acceptance or on reset. If TIMEOUT_CYCLES=0, timeout_err stays 0.
- Reset mid-transaction: all outputs return to reset values immediately; the in-flight command is lost and no response is produced.
- rsp_rdata is forced to 0 for writes.

Decomposition:
- Package axi_lite_pkg: resp codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the state enum.
- Sub-module axi_lite_wdog: saturating counter with clear/enable/expire, parametrised by TIMEOUT_CYCLES. It is reusable by the future slave.

Test Plan:
- Write 0x0000_0010 ← 0xDEAD_BEEF, wstrb=4'hF, zero-wait slave -> AW/W handshake on the same cycle, bresp=OKAY, rsp_valid 3 cycles after cmd accept, rsp_resp=00.
- Write with awready delayed 4 cycles and wready at 0 delay -> wvalid drops after 1 cycle, awvalid held stable for 4 cycles, exactly one B accepted, correct response.
- Read 0x0000_0020, slave returns 0x1234_5678/SLVERR after 2 wait cycles -> rsp_rdata=0x1234_5678, rsp_resp=10, rsp_write=0.
- rsp_ready held low for 5 cycles -> rsp_* stable, cmd_ready=0 throughout, new cmd accepted only after the response handshake.
- TIMEOUT_CYCLES=8, bvalid withheld for 20 cycles -> timeout_err=1 at 8 cycles, bready held, response delivered normally; next cmd clears the flag.
- aresetn pulsed low during RD_DATA -> all valids/readys go to 0 asynchronously, no rsp_valid, next read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding and
// a small helper used to gate the watchdog.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  // States in which the master is waiting on the slave.
  function automatic logic is_busy(state_t s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_wdog.sv
// Saturating per-phase cycle counter; expired once it has counted
// TIMEOUT_CYCLES enabled cycles. TIMEOUT_CYCLES = 0 disables it.
module axi_lite_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic ACTIVE = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt;

  // A clear on the first cycle of a new phase still counts that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= (en && ACTIVE) ? CW'(1) : '0;
    else if (en && cnt != LIMIT)  cnt <= cnt + CW'(1);
  end

  assign expired = ACTIVE && (cnt == LIMIT);
endmodule

// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite master: one command in, one full AXI-Lite transaction out,
// one handshaked response back. Single outstanding transaction.
module axi_lite_master_cmd
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_lite_aclk,
  input  logic                    axi_lite_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout_err,
  axi_lite_if.master              axi_lite
);
  state_t state, state_prev;
  logic   wd_clr, wd_expired;

  assign wd_clr = (state != state_prev);

  axi_lite_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (axi_lite_aclk),
    .rst_n   (axi_lite_aresetn),
    .clr     (wd_clr),
    .en      (is_busy(state)),
    .expired (wd_expired)
  );

  always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      state            <= IDLE;
      state_prev       <= IDLE;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_write        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_resp         <= 2'b00;
      timeout_err      <= 1'b0;
      axi_lite.awaddr  <= '0;
      axi_lite.awprot  <= 3'b000;
      axi_lite.awvalid <= 1'b0;
      axi_lite.wdata   <= '0;
      axi_lite.wstrb   <= '0;
      axi_lite.wvalid  <= 1'b0;
      axi_lite.bready  <= 1'b0;
      axi_lite.araddr  <= '0;
      axi_lite.arprot  <= 3'b000;
      axi_lite.arvalid <= 1'b0;
      axi_lite.rready  <= 1'b0;
    end else begin
      state_prev <= state;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            timeout_err <= 1'b0;
            rsp_write   <= cmd_write;
            if (cmd_write) begin
              axi_lite.awaddr  <= cmd_addr;
              axi_lite.awprot  <= cmd_prot;
              axi_lite.wdata   <= cmd_wdata;
              axi_lite.wstrb   <= cmd_wstrb;
              axi_lite.awvalid <= 1'b1;
              axi_lite.wvalid  <= 1'b1;
              state            <= WR_REQ;
            end else begin
              axi_lite.araddr  <= cmd_addr;
              axi_lite.arprot  <= cmd_prot;
              axi_lite.arvalid <= 1'b1;
              state            <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; move on once neither is pending.
          if (axi_lite.awvalid && axi_lite.awready) axi_lite.awvalid <= 1'b0;
          if (axi_lite.wvalid && axi_lite.wready)   axi_lite.wvalid  <= 1'b0;
          if ((!axi_lite.awvalid || axi_lite.awready) &&
              (!axi_lite.wvalid  || axi_lite.wready)) begin
            axi_lite.bready <= 1'b1;
            state           <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_lite.bvalid) begin
            axi_lite.bready <= 1'b0;
            rsp_resp        <= axi_lite.bresp;
            rsp_rdata       <= '0;
            rsp_valid       <= 1'b1;
            state           <= RSP;
          end
        end
        RD_REQ: begin
          if (axi_lite.arready) begin
            axi_lite.arvalid <= 1'b0;
            axi_lite.rready  <= 1'b1;
            state            <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_lite.rvalid) begin
            axi_lite.rready <= 1'b0;
            rsp_rdata       <= axi_lite.rdata;
            rsp_resp        <= axi_lite.rresp;
            rsp_valid       <= 1'b1;
            state           <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Counter is always back at zero by the time IDLE accepts a command.
      if (wd_expired) timeout_err <= 1'b1;
    end
  end
endmodule
